unified_mem_arbiter: RTL and testbench

- Shares one memory_io port between the core's instruction-fetch requester and its data (load/store) requester, so the core can run against a single unified memory.
- Sits between the core's inst_mem_req/rsp and data_mem_req/rsp pairs and the memory model.
- Each requester has a one-entry holding slot.
- Slots are served one transaction at a time, in round-robin order, with response data routed back to the owner.
- Per-requester grant counters are kept for performance accounting.

---
 rtl/unified_mem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the inst and data requesters.
// Ports: clk, reset, inst_req/rsp, data_req/rsp, mem_req/rsp, grant counters, protocol_error.
//
// Packed request layout (73 bits): {addr[31:0], valid, do_read[3:0], do_write[3:0], data[31:0]}
// Packed response layout (34 bits): {ready, valid, data[31:0]}
module unified_mem_arbiter #(
    parameter int COUNT_WIDTH = 32,
    parameter bit INST_FIRST  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [72:0]            inst_req,
    output logic [33:0]            inst_rsp,
    input  logic [72:0]            data_req,
    output logic [33:0]            data_rsp,
    output logic [72:0]            mem_req,
    input  logic [33:0]            mem_rsp,
    output logic [COUNT_WIDTH-1:0] inst_grant_count,
    output logic [COUNT_WIDTH-1:0] data_grant_count,
    output logic                   protocol_error
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t state, state_n;
    logic   owner, owner_n;
    logic   last_served;

    logic        i_full, d_full;
    logic [31:0] i_addr, d_addr;
    logic [3:0]  i_rd, d_rd;
    logic [3:0]  i_wr, d_wr;
    logic [31:0] i_data, d_data;

    logic        m_ready, m_valid;
    logic [31:0] m_data;

    logic        i_acc, d_acc;
    logic        i_rv, d_rv;
    logic [31:0] i_rdata, d_rdata;
    logic        inc_i, inc_d;
    logic        done;
    logic        stray;

    assign m_ready = mem_rsp[33];
    assign m_valid = mem_rsp[32];
    assign m_data  = mem_rsp[31:0];

    assign i_acc = inst_req[40] && !i_full;
    assign d_acc = data_req[40] && !d_full;

    // Ready reflects only slot occupancy, so requesters may gate valid on it.
    assign inst_rsp = {!i_full, i_rv, i_rdata};
    assign data_rsp = {!d_full, d_rv, d_rdata};

    always_comb begin
        state_n = state;
        owner_n = owner;
        mem_req = '0;
        i_rv    = 1'b0;
        d_rv    = 1'b0;
        i_rdata = '0;
        d_rdata = '0;
        inc_i   = 1'b0;
        inc_d   = 1'b0;
        done    = 1'b0;
        stray   = 1'b0;
        unique case (state)
            IDLE: begin
                stray = m_valid;
                if (i_full && d_full) begin
                    // Tie: serve whoever was not served last.
                    owner_n = ~last_served;
                    state_n = ISSUE;
                end else if (i_full) begin
                    owner_n = OWN_INST;
                    state_n = ISSUE;
                end else if (d_full) begin
                    owner_n = OWN_DATA;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                stray = m_valid;
                if (m_ready) begin
                    if (owner == OWN_DATA) begin
                        mem_req = {d_addr, 1'b1, d_rd, d_wr, d_data};
                        inc_d   = 1'b1;
                    end else begin
                        mem_req = {i_addr, 1'b1, i_rd, i_wr, i_data};
                        inc_i   = 1'b1;
                    end
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (m_valid) begin
                    done = 1'b1;
                    if (owner == OWN_DATA) begin
                        d_rv    = 1'b1;
                        d_rdata = m_data;
                    end else begin
                        i_rv    = 1'b1;
                        i_rdata = m_data;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= OWN_INST;
            last_served      <= INST_FIRST ? OWN_DATA : OWN_INST;
            i_full           <= 1'b0;
            d_full           <= 1'b0;
            i_addr           <= '0;
            i_rd             <= '0;
            i_wr             <= '0;
            i_data           <= '0;
            d_addr           <= '0;
            d_rd             <= '0;
            d_wr             <= '0;
            d_data           <= '0;
            inst_grant_count <= '0;
            data_grant_count <= '0;
            protocol_error   <= 1'b0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            // Accept needs an empty slot and release needs a full one,
            // so the two never collide on the same slot.
            if (i_acc) begin
                i_full <= 1'b1;
                i_addr <= inst_req[72:41];
                i_rd   <= inst_req[39:36];
                i_wr   <= inst_req[35:32];
                i_data <= inst_req[31:0];
            end else if (done && owner == OWN_INST) begin
                i_full <= 1'b0;
            end
            if (d_acc) begin
                d_full <= 1'b1;
                d_addr <= data_req[72:41];
                d_rd   <= data_req[39:36];
                d_wr   <= data_req[35:32];
                d_data <= data_req[31:0];
            end else if (done && owner == OWN_DATA) begin
                d_full <= 1'b0;
            end
            if (done) begin
                last_served <= owner;
            end
            if (inc_i) begin
                inst_grant_count <= inst_grant_count + COUNT_WIDTH'(1);
            end
            if (inc_d) begin
                data_grant_count <= data_grant_count + COUNT_WIDTH'(1);
            end
            if (stray) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a 1-cycle memory model.
// Ports: drives all DUT inputs, checks responses, counters and error flag.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [72:0] inst_req;
    logic [33:0] inst_rsp;
    logic [72:0] data_req;
    logic [33:0] data_rsp;
    logic [72:0] mem_req;
    logic [33:0] mem_rsp;
    logic [3:0]  icnt;
    logic [3:0]  dcnt;
    logic        perr;

    logic        rdy;
    logic        rv;
    logic [31:0] rdat;
    logic        mute;

    logic [31:0] memory [logic [31:0]];

    int checks;
    int errors;
    int grants;
    logic seen;

    assign mem_rsp = {rdy, rv, rdat};

    unified_mem_arbiter #(
        .COUNT_WIDTH(4),
        .INST_FIRST (1'b1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_req        (inst_req),
        .inst_rsp        (inst_rsp),
        .data_req        (data_req),
        .data_rsp        (data_rsp),
        .mem_req         (mem_req),
        .mem_rsp         (mem_rsp),
        .inst_grant_count(icnt),
        .data_grant_count(dcnt),
        .protocol_error  (perr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [72:0] mk(
        input logic [31:0] a,
        input logic        v,
        input logic [3:0]  r,
        input logic [3:0]  w,
        input logic [31:0] d
    );
        return {a, v, r, w, d};
    endfunction

    function automatic logic [33:0] rsp(
        input logic        r,
        input logic        v,
        input logic [31:0] d
    );
        return {r, v, d};
    endfunction

    function automatic logic [31:0] rdmem(input logic [31:0] a);
        if (memory.exists(a)) return memory[a];
        return ~a;
    endfunction

    task automatic chk(
        input string       tag,
        input logic [72:0] obs,
        input logic [72:0] exp
    );
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Memory accepts whatever is presented at the edge and answers
    // in the following cycle; writes echo their data.
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        logic [31:0] d;
        #1;
        acc = mem_req[40];
        a   = mem_req[72:41];
        d   = 32'h0;
        if (acc) begin
            if (mem_req[35:32] != 4'h0) begin
                memory[a] = mem_req[31:0];
                d = mem_req[31:0];
            end else begin
                d = rdmem(a);
            end
        end
        @(posedge clk);
        #1;
        rv   = acc && !mute;
        rdat = d;
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        inst_req = '0;
        data_req = '0;
        rdy      = 1'b1;
        mute     = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        inst_req = '0;
        data_req = '0;
        rdy      = 1'b1;
        rv       = 1'b0;
        rdat     = '0;
        mute     = 1'b0;
        memory[32'h100] = 32'h0050_0093;

        // Reset state
        do_reset();
        chk("rst_mem_req", mem_req, 73'(0));
        chk("rst_inst_rsp", 73'(inst_rsp), 73'(rsp(1, 0, 0)));
        chk("rst_data_rsp", 73'(data_rsp), 73'(rsp(1, 0, 0)));
        chk("rst_icnt", 73'(icnt), 73'(0));
        chk("rst_dcnt", 73'(dcnt), 73'(0));
        chk("rst_perr", 73'(perr), 73'(0));

        // Single fetch
        inst_req = mk(32'h100, 1, 4'hF, 4'h0, 0);
        tick();
        inst_req = '0;
        chk("f_c1_rdy", 73'(inst_rsp[33]), 73'(0));
        chk("f_c1_mreq", 73'(mem_req[40]), 73'(0));
        tick();
        chk("f_c2_mreq", mem_req, mk(32'h100, 1, 4'hF, 4'h0, 0));
        chk("f_c2_rdy", 73'(inst_rsp[33]), 73'(0));
        tick();
        chk("f_c3_rsp", 73'(inst_rsp), 73'(rsp(0, 1, 32'h0050_0093)));
        chk("f_c3_drsp", 73'(data_rsp), 73'(rsp(1, 0, 0)));
        chk("f_icnt", 73'(icnt), 73'(1));
        tick();
        chk("f_c4_rsp", 73'(inst_rsp), 73'(rsp(1, 0, 0)));

        // Simultaneous requests, inst wins the first tie
        do_reset();
        inst_req = mk(32'h200, 1, 4'hF, 4'h0, 0);
        data_req = mk(32'h1000, 1, 4'h0, 4'hF, 32'hDEAD_BEEF);
        tick();
        inst_req = '0;
        data_req = '0;
        chk("s_c1_irdy", 73'(inst_rsp[33]), 73'(0));
        chk("s_c1_drdy", 73'(data_rsp[33]), 73'(0));
        tick();
        chk("s_c2_mreq", mem_req, mk(32'h200, 1, 4'hF, 4'h0, 0));
        tick();
        chk("s_c3_irsp", 73'(inst_rsp), 73'(rsp(0, 1, ~32'h200)));
        chk("s_c3_drsp", 73'(data_rsp), 73'(rsp(0, 0, 0)));
        tick();
        chk("s_c4_mreq", mem_req, 73'(0));
        chk("s_c4_irdy", 73'(inst_rsp[33]), 73'(1));
        tick();
        chk("s_c5_mreq", mem_req,
            mk(32'h1000, 1, 4'h0, 4'hF, 32'hDEAD_BEEF));
        tick();
        chk("s_c6_drsp", 73'(data_rsp), 73'(rsp(0, 1, 32'hDEAD_BEEF)));
        chk("s_c6_irsp", 73'(inst_rsp), 73'(rsp(1, 0, 0)));
        tick();
        chk("s_c7_drdy", 73'(data_rsp[33]), 73'(1));
        chk("s_icnt", 73'(icnt), 73'(1));
        chk("s_dcnt", 73'(dcnt), 73'(1));

        // Back-pressure during ISSUE
        rdy = 1'b0;
        inst_req = mk(32'h300, 1, 4'hF, 4'h0, 0);
        tick();
        inst_req = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_stall_mreq", mem_req, 73'(0));
            chk("bp_stall_icnt", 73'(icnt), 73'(1));
            tick();
        end
        rdy = 1'b1;
        #1;
        chk("bp_go_mreq", mem_req, mk(32'h300, 1, 4'hF, 4'h0, 0));
        tick();
        chk("bp_rsp", 73'(inst_rsp), 73'(rsp(0, 1, ~32'h300)));
        chk("bp_icnt", 73'(icnt), 73'(2));
        tick();
        tick();
        chk("bp_icnt_once", 73'(icnt), 73'(2));

        // Fairness with both requesters always refilling
        do_reset();
        inst_req = mk(32'h400, 1, 4'hF, 4'h0, 0);
        data_req = mk(32'h800, 1, 4'h0, 4'hF, 32'h1234_5678);
        grants = 0;
        for (int c = 0; c < 100 && grants < 8; c++) begin
            if (mem_req[40]) begin
                chk("fair_order", 73'(mem_req[72:41] == 32'h800),
                    73'(grants % 2));
                grants++;
                if (grants == 8) begin
                    inst_req = '0;
                    data_req = '0;
                end
            end
            tick();
        end
        chk("fair_grants", 73'(grants), 73'(8));
        chk("fair_icnt", 73'(icnt), 73'(4));
        chk("fair_dcnt", 73'(dcnt), 73'(4));

        // Reset in WAIT, then a late response
        do_reset();
        inst_req = mk(32'h500, 1, 4'hF, 4'h0, 0);
        tick();
        inst_req = '0;
        tick();
        chk("rw_issue", 73'(mem_req[40]), 73'(1));
        mute = 1'b1;
        tick();
        chk("rw_wait_iv", 73'(inst_rsp[32]), 73'(0));
        reset = 1'b1;
        data_req = mk(32'h900, 1, 4'hF, 4'h0, 0);
        tick();
        reset = 1'b0;
        data_req = '0;
        rv   = 1'b1;
        rdat = 32'hCAFE_F00D;
        #1;
        chk("rw_irsp", 73'(inst_rsp), 73'(rsp(1, 0, 0)));
        chk("rw_drsp", 73'(data_rsp), 73'(rsp(1, 0, 0)));
        chk("rw_icnt", 73'(icnt), 73'(0));
        tick();
        chk("rw_perr", 73'(perr), 73'(1));
        chk("rw_irsp2", 73'(inst_rsp), 73'(rsp(1, 0, 0)));
        chk("rw_drsp2", 73'(data_rsp), 73'(rsp(1, 0, 0)));
        chk("rw_mreq", mem_req, 73'(0));
        mute = 1'b0;

        // Counter wrap with 4-bit counters
        do_reset();
        chk("cw_perr_clr", 73'(perr), 73'(0));
        for (int n = 0; n < 17; n++) begin
            inst_req = mk(32'h600 + 32'(n * 4), 1, 4'hF, 4'h0, 0);
            tick();
            inst_req = '0;
            seen = 1'b0;
            for (int j = 0; j < 10 && !seen; j++) begin
                tick();
                if (inst_rsp[32]) seen = 1'b1;
            end
            chk("cw_rsp_seen", 73'(seen), 73'(1));
            tick();
        end
        chk("cw_icnt", 73'(icnt), 73'(1));
        chk("cw_dcnt", 73'(dcnt), 73'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
